// File: rtl/h14tx_pkg.sv
// Shared TMDS types and constants for the HDMI 1.4 transmit path.
// Carries the symbol type, period modes, sequencer states and the fixed control/guard codes.
package h14tx_pkg;

  localparam int unsigned SymbolWidth = 10;
  localparam int unsigned NumChannels = 3;

  typedef logic [SymbolWidth-1:0] symbol_t;
  typedef symbol_t [NumChannels-1:0] symbol_bus_t;

  typedef enum logic {
    MODE_VIDEO  = 1'b0,
    MODE_ISLAND = 1'b1
  } period_mode_t;

  typedef enum logic [2:0] {
    ST_CTRL     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_LEAD     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_TRAIL    = 3'd4
  } period_state_t;

  localparam symbol_t GUARD_A     = 10'b1011001100;
  localparam symbol_t GUARD_B     = 10'b0100110011;

  localparam symbol_t CTRL_SYM_00 = 10'b1101010100;
  localparam symbol_t CTRL_SYM_01 = 10'b0010101011;
  localparam symbol_t CTRL_SYM_10 = 10'b0101010100;
  localparam symbol_t CTRL_SYM_11 = 10'b1010101011;

  // Maps the two CTL bits {D1,D0} of a channel to its control-period symbol.
  function automatic symbol_t ctrl_symbol(input logic [1:0] d);
    symbol_t sym;
    case (d)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/h14tx_ctrl_encode.sv
// Combinational control-period encoder: two CTL bits to one TMDS control symbol.
module h14tx_ctrl_encode
  import h14tx_pkg::*;
(
  input  logic [1:0] ctl_i,
  output symbol_t    symbol_o
);

  always_comb begin
    symbol_o = CTRL_SYM_00;
    symbol_o = ctrl_symbol(ctl_i);
  end

endmodule

// File: rtl/h14tx_period_sequencer.sv
// Sequences each TMDS channel through control, preamble, leading guard, payload and
// (data islands only) trailing guard, feeding the serialiser-side symbol register.
module h14tx_period_sequencer
  import h14tx_pkg::*;
#(
  parameter int unsigned PreambleLen = 8,
  parameter int unsigned GuardLen    = 2,
  parameter int unsigned MinCtrlLen  = 12,
  parameter int unsigned LenWidth    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  period_mode_t        mode,
  input  logic [LenWidth-1:0] payload_len,
  input  logic                hsync,
  input  logic                vsync,
  input  symbol_bus_t         video_symbol,
  input  symbol_bus_t         island_symbol,
  input  symbol_t             island_guard0,
  output logic                ready,
  output logic                payload_take,
  output logic                busy,
  output symbol_bus_t         symbol
);

  localparam int unsigned PhaseWidth = 4;
  localparam int unsigned CtrlWidth  = 6;

  localparam logic [PhaseWidth-1:0] PreLast   = PhaseWidth'(PreambleLen - 1);
  localparam logic [PhaseWidth-1:0] GuardLast = PhaseWidth'(GuardLen - 1);
  localparam logic [CtrlWidth-1:0]  CtrlMax   = CtrlWidth'(MinCtrlLen);
  localparam logic [LenWidth-1:0]   LenOne    = LenWidth'(1);

  period_state_t         state_q;
  period_mode_t          mode_q;
  logic [PhaseWidth-1:0] phase_q;
  logic [LenWidth-1:0]   len_q;
  logic [CtrlWidth-1:0]  ctrl_q;
  symbol_bus_t           symbol_q;
  symbol_bus_t           symbol_d;

  logic [NumChannels-1:0][1:0] ctl_bits;
  symbol_bus_t                 ctl_sym;

  logic accept;
  logic is_island;

  assign ready        = (state_q == ST_CTRL) && (ctrl_q == CtrlMax);
  assign payload_take = (state_q == ST_PAYLOAD);
  assign busy         = (state_q != ST_CTRL);
  assign accept       = start && ready;
  assign is_island    = (mode_q == MODE_ISLAND);
  assign symbol       = symbol_q;

  // CTL bits per channel; channels 1/2 only carry the preamble pattern during PREAMBLE.
  always_comb begin
    ctl_bits[0] = {vsync, hsync};
    ctl_bits[1] = 2'b00;
    ctl_bits[2] = 2'b00;
    if (state_q == ST_PREAMBLE) begin
      ctl_bits[1] = 2'b01;
      ctl_bits[2] = is_island ? 2'b01 : 2'b00;
    end
  end

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ctl
    h14tx_ctrl_encode u_ctrl_encode (
      .ctl_i    (ctl_bits[ch]),
      .symbol_o (ctl_sym[ch])
    );
  end

  // Next output symbols selected by the current state.
  always_comb begin
    symbol_d = ctl_sym;
    case (state_q)
      ST_LEAD, ST_TRAIL: begin
        if (is_island) begin
          symbol_d = {GUARD_B, GUARD_B, island_guard0};
        end else begin
          symbol_d = {GUARD_A, GUARD_B, GUARD_A};
        end
      end
      ST_PAYLOAD: symbol_d = is_island ? island_symbol : video_symbol;
      default:    symbol_d = ctl_sym;
    endcase
  end

  // Period FSM, phase/length/control counters and the output symbol register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CTRL;
      mode_q   <= MODE_VIDEO;
      phase_q  <= '0;
      len_q    <= '0;
      ctrl_q   <= '0;
      symbol_q <= {CTRL_SYM_00, CTRL_SYM_00, CTRL_SYM_00};
    end else begin
      symbol_q <= symbol_d;
      case (state_q)
        ST_CTRL: begin
          if (accept) begin
            mode_q  <= mode;
            len_q   <= payload_len;
            ctrl_q  <= '0;
            phase_q <= '0;
            state_q <= ST_PREAMBLE;
          end else if (ctrl_q != CtrlMax) begin
            ctrl_q <= ctrl_q + CtrlWidth'(1);
          end
        end
        ST_PREAMBLE: begin
          if (phase_q == PreLast) begin
            phase_q <= '0;
            state_q <= ST_LEAD;
          end else begin
            phase_q <= phase_q + PhaseWidth'(1);
          end
        end
        ST_LEAD: begin
          if (phase_q == GuardLast) begin
            phase_q <= '0;
            if (len_q != '0) begin
              state_q <= ST_PAYLOAD;
            end else if (is_island) begin
              state_q <= ST_TRAIL;
            end else begin
              state_q <= ST_CTRL;
            end
          end else begin
            phase_q <= phase_q + PhaseWidth'(1);
          end
        end
        ST_PAYLOAD: begin
          len_q <= len_q - LenOne;
          if (len_q == LenOne) begin
            state_q <= is_island ? ST_TRAIL : ST_CTRL;
          end
        end
        ST_TRAIL: begin
          if (phase_q == GuardLast) begin
            phase_q <= '0;
            state_q <= ST_CTRL;
          end else begin
            phase_q <= phase_q + PhaseWidth'(1);
          end
        end
        default: begin
          phase_q <= '0;
          state_q <= ST_CTRL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h14tx_period_sequencer.sv
// Directed bench for h14tx_period_sequencer: expected symbols are queued when inputs are
// driven and checked one cycle later; status outputs are checked against the period schedule.
module tb_h14tx_period_sequencer;
  import h14tx_pkg::*;

  localparam int PRE      = 8;
  localparam int GUARD    = 2;
  localparam int MIN_CTRL = 12;
  localparam int LEN_W    = 12;

  typedef enum int {PH_CTRL, PH_PRE, PH_LEAD, PH_PAY, PH_TRAIL} ph_e;

  logic              clk;
  logic              rst;
  logic              start;
  period_mode_t      mode;
  logic [LEN_W-1:0]  payload_len;
  logic              hsync;
  logic              vsync;
  symbol_bus_t       video_symbol;
  symbol_bus_t       island_symbol;
  symbol_t           island_guard0;
  logic              ready;
  logic              payload_take;
  logic              busy;
  symbol_bus_t       symbol;

  h14tx_period_sequencer #(
    .PreambleLen (PRE),
    .GuardLen    (GUARD),
    .MinCtrlLen  (MIN_CTRL),
    .LenWidth    (LEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .payload_len   (payload_len),
    .hsync         (hsync),
    .vsync         (vsync),
    .video_symbol  (video_symbol),
    .island_symbol (island_symbol),
    .island_guard0 (island_guard0),
    .ready         (ready),
    .payload_take  (payload_take),
    .busy          (busy),
    .symbol        (symbol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            total = 0;
  int            bad   = 0;
  int            ctrl_seen = 0;
  int            busy_cnt = 0;
  int            take_cnt = 0;
  logic          rand_sync = 1'b0;
  logic [9:0]    g0 = 10'b1011100100;
  logic [29:0]   sq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctl(input logic [1:0] d);
    case (d)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Symbol expected one cycle after a cycle in phase ph with the inputs now on the pins.
  function automatic logic [29:0] exp_sym(input ph_e ph, input logic isl);
    case (ph)
      PH_PRE:  return {(isl ? ctl(2'b01) : ctl(2'b00)), ctl(2'b01), ctl({vsync, hsync})};
      PH_LEAD, PH_TRAIL:
        return isl ? {10'b0100110011, 10'b0100110011, g0}
                   : {10'b1011001100, 10'b0100110011, 10'b1011001100};
      PH_PAY:  return isl ? island_symbol : video_symbol;
      default: return {ctl(2'b00), ctl(2'b00), ctl({vsync, hsync})};
    endcase
  endfunction

  // One clock cycle: check outputs, drive inputs, queue the expected next symbol, advance.
  task automatic cycle(input ph_e ph, input logic isl, input logic exp_ready, input logic st);
    logic [29:0] e;
    if (sq.size() != 0) begin
      e = sq.pop_front();
      chk("symbol", 32'(symbol), 32'(e));
    end
    chk("busy", 32'(busy), 32'(ph != PH_CTRL));
    chk("payload_take", 32'(payload_take), 32'(ph == PH_PAY));
    chk("ready", 32'(ready), 32'(exp_ready));
    if (busy === 1'b1) busy_cnt++;
    if (payload_take === 1'b1) take_cnt++;
    start = st;
    if (rand_sync) begin
      hsync = 1'($urandom);
      vsync = 1'($urandom);
    end
    video_symbol  = 30'($urandom);
    island_symbol = 30'($urandom);
    island_guard0 = g0;
    sq.push_back(exp_sym(ph, isl));
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_cycle(input logic st);
    cycle(PH_CTRL, 1'b0, ctrl_seen >= MIN_CTRL, st);
    ctrl_seen++;
  endtask

  task automatic wait_ready();
    while (ctrl_seen < MIN_CTRL) ctrl_cycle(1'b0);
  endtask

  task automatic do_reset();
    logic [29:0] e;
    if (sq.size() != 0) begin
      e = sq.pop_front();
      chk("symbol_before_reset", 32'(symbol), 32'(e));
    end
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    sq.delete();
    chk("reset_symbol", 32'(symbol), 32'({3{10'b1101010100}}));
    chk("reset_ready", 32'(ready), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_take", 32'(payload_take), 32'(0));
    rst       = 1'b0;
    ctrl_seen = 0;
  endtask

  // Runs one requested period from its acceptance cycle; abort_at >= 0 resets mid-payload.
  task automatic period(input logic isl, input int len, input int abort_at, input int exp_busy);
    mode        = isl ? MODE_ISLAND : MODE_VIDEO;
    payload_len = LEN_W'(len);
    busy_cnt    = 0;
    take_cnt    = 0;
    cycle(PH_CTRL, isl, ctrl_seen >= MIN_CTRL, 1'b1);
    mode        = isl ? MODE_VIDEO : MODE_ISLAND;
    payload_len = LEN_W'(len + 5);
    for (int i = 0; i < PRE; i++) cycle(PH_PRE, isl, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < GUARD; i++) cycle(PH_LEAD, isl, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      cycle(PH_PAY, isl, 1'b0, 1'($urandom_range(0, 1)));
    end
    if (isl) begin
      for (int i = 0; i < GUARD; i++) cycle(PH_TRAIL, isl, 1'b0, 1'($urandom_range(0, 1)));
    end
    start     = 1'b0;
    ctrl_seen = 0;
    chk("payload_take_count", 32'(take_cnt), 32'(len));
    chk("busy_count", 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    mode          = MODE_VIDEO;
    payload_len   = '0;
    hsync         = 1'b0;
    vsync         = 1'b0;
    video_symbol  = '0;
    island_symbol = '0;
    island_guard0 = g0;

    do_reset();

    // start held from reset release: accepted only once ready rises in cycle 12.
    for (int k = 0; k < MIN_CTRL; k++) ctrl_cycle(1'b1);
    period(1'b0, 4, -1, PRE + GUARD + 4);

    // start one cycle after the period ends is dropped.
    rand_sync = 1'b1;
    ctrl_cycle(1'b1);
    wait_ready();

    g0 = 10'b1011100100;
    period(1'b1, 32, -1, 44);

    ctrl_cycle(1'b1);
    wait_ready();
    period(1'b1, 0, -1, PRE + 2 * GUARD);

    wait_ready();
    period(1'b0, 0, -1, PRE + GUARD);

    wait_ready();
    g0 = 10'($urandom);
    period(1'b1, 3, -1, PRE + 2 * GUARD + 3);

    // Reset mid-payload: straight back to control symbols, no trailing guard.
    wait_ready();
    period(1'b1, 6, 3, 0);
    wait_ready();
    period(1'b0, 2, -1, PRE + GUARD + 2);
    for (int k = 0; k < 3; k++) ctrl_cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/h14tx_period_sequencer.md
# h14tx_period_sequencer

Sequential successor to the fixed guard-band mux in the HDMI 1.4 TMDS encoding path. It sits between the per-channel TMDS/TERC4 encoders and the serialiser-side symbol register. On each accepted period request it drives every channel through control, preamble, leading guard band, payload and (for data islands) trailing guard band. Phase lengths and the minimum control-period spacing are parametrised.

## Interface
- `PreambleLen`, default 8: preamble cycles; legal range 1..15.
- `GuardLen`, default 2: leading and trailing guard-band cycles; legal range 1..3.
- `MinCtrlLen`, default 12: CTRL-state cycles required before the next request is accepted; legal range 1..63.
- `LenWidth`, default 12: width of `payload_len`.

Ports:
- `clk` in 1: pixel clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: period request. Accepted only when `start && ready`.
- `mode` in `period_mode_t`: `MODE_VIDEO` or `MODE_ISLAND`. Sampled only on acceptance.
- `payload_len` in LenWidth: payload cycle count. Sampled only on acceptance; 0 is legal.
- `hsync`, `vsync` in 1 each: sampled every cycle, used for the channel-0 control symbol.
- `video_symbol` in 3×`symbol_t`: TMDS-encoded video payload, one symbol per channel.
- `island_symbol` in 3×`symbol_t`: TERC4-encoded island payload, one symbol per channel.
- `island_guard0` in `symbol_t`: TERC4 channel-0 guard symbol for the island, supplied upstream.
- `ready` out 1: block can accept a request.
- `payload_take` out 1: payload inputs are consumed this cycle.
- `busy` out 1: FSM is not in CTRL.
- `symbol` out 3×`symbol_t`: registered output symbols.

## Operation
- FSM states: CTRL, PREAMBLE, LEAD, PAYLOAD, TRAIL.
- Phase counter: 4 bits. Length counter: LenWidth bits. Control counter: 6 bits, saturating.
- CTRL:
  - The control counter increments each CTRL cycle and saturates at MinCtrlLen.
  - `ready` = (state == CTRL) && (ctrl_cnt == MinCtrlLen).
  - On acceptance: latch `mode` and `payload_len`, clear the control counter, go to PREAMBLE.
- PREAMBLE: PreambleLen cycles, then LEAD.
- LEAD: GuardLen cycles. Then go to PAYLOAD if the latched length is nonzero. Otherwise go to TRAIL (island) or CTRL (video).
- PAYLOAD: latched-length cycles with `payload_take`=1. Then go to TRAIL (island) or CTRL (video).
- TRAIL (island only): GuardLen cycles, then CTRL.
- Symbol content by state:
  - CTRL: every channel carries a control symbol. Channel 0 uses CTL bits {vsync,hsync}; channels 1 and 2 use CTL bits 00.
  - PREAMBLE: channel 0 as in CTRL. Channels 1 and 2 carry {CTL1,CTL0} and {CTL3,CTL2}. Video uses CTL0..3 = 1,0,0,0. Island uses CTL0..3 = 1,0,1,0.
  - LEAD, video: ch0 = 1011001100, ch1 = 0100110011, ch2 = 1011001100.
  - LEAD/TRAIL, island: ch0 = `island_guard0`, ch1 = ch2 = 0100110011.
  - PAYLOAD: `video_symbol` or `island_symbol`, selected by the latched mode.
- Control encoding, D1D0 → symbol: 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011.
- A `start` asserted while `ready`=0 is ignored. It is not queued.
- Changes to `mode` or `payload_len` outside acceptance have no effect.
- Reset:
  - State returns to CTRL, all counters clear.
  - Reset mid-period aborts the period immediately; no trailing guard is emitted.

## Timing
- Cycle 0 is the acceptance cycle.
- FSM occupancy:
  - PREAMBLE: cycles 1..P.
  - LEAD: cycles P+1..P+G.
  - PAYLOAD: cycles P+G+1..P+G+L.
  - TRAIL (island): the following G cycles.
- `payload_take` is high exactly during PAYLOAD cycles. Payload inputs sampled in cycle k appear on `symbol` in cycle k+1.
- `symbol` always reflects the previous cycle's state, i.e. one-cycle registered latency.
- `busy` is combinational from state.
- Reset values: `symbol` = 1101010100 on all three channels; `ready`=0, `payload_take`=0, `busy`=0.
- After reset or period end, `ready` rises after exactly MinCtrlLen CTRL cycles.

## Structure
- Add to `h14tx_pkg`:
  - `period_mode_t`.
  - Guard constants `GUARD_A` (1011001100) and `GUARD_B` (0100110011).
  - The four control-symbol constants.
  - Existing `symbol_t` is reused.
- One sub-module, `h14tx_ctrl_encode`: a combinational 2-bit → `symbol_t` control encoder, instantiated per channel.
- The FSM, counters and output register live in the top module.

## Test plan
- Reset, then hold `start`=1 → `ready` is 0 for cycles 0..11 and goes high in cycle 12; `symbol` stays 1101010100 on all channels throughout.
- Video request, P=8, G=2, L=4 → ch1/ch2 show 0010101011/1101010100 for 8 cycles, then the video guard for 2 cycles, then 4 `video_symbol` values, then control symbols; `payload_take` is high for exactly 4 cycles.
- Island request, L=32, `island_guard0`=1011100100 → ch2 preamble 0010101011, ch0 guard 1011100100 both leading and trailing; `busy` lasts 44 cycles.
- Island request with L=0 → LEAD goes directly to TRAIL, 4 guard cycles total, `payload_take` never asserts.
- `start` pulsed in the cycle after a period ends → ignored; the request is accepted only once `ready` returns.
- `rst` asserted mid-PAYLOAD → the next cycle shows control symbols with `busy`=0; no trailing guard is emitted.
